// File: rtl/operand_mux_pipe.sv
// Operand select mux feeding a 2-entry FIFO (output register plus skid register).
// The FIFO accepts on in_valid&&in_ready and delivers on out_valid&&out_ready, and it keeps operands in order.
module operand_mux_pipe #(
  parameter int WIDTH = 40,
  parameter int NSRC  = 5,
  parameter int SELW  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  d_in,
  input  logic [SELW-1:0]       ins,
  input  logic [NSRC*WIDTH-1:0] src,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      a_o,
  output logic [SELW-1:0]       out_ins,
  output logic                  sel_err,
  output logic [15:0]           count,
  output logic [1:0]            occ_dbg_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t             occ_q, occ_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SELW-1:0]  out_ins_q, out_ins_d;
  logic [SELW-1:0]  skid_ins_q, skid_ins_d;
  logic             in_ready_q, in_ready_d;
  logic             sel_err_q, sel_err_d;
  logic [15:0]      count_q, count_d;

  logic [WIDTH-1:0] new_data;
  logic [SELW-1:0]  new_ins;
  logic             new_err;
  logic             accept;
  logic             xfer;

  // The override wins over any select code. Out-of-range codes deliver zero with code 0.
  always_comb begin
    new_data = '0;
    new_ins  = '0;
    new_err  = 1'b0;
    if (d_in) begin
      new_data = src[WIDTH-1:0];
      new_ins  = SELW'(1);
    end else if (int'(ins) > NSRC) begin
      new_err = 1'b1;
    end else begin
      for (int k = 1; k <= NSRC; k++) begin
        if (int'(ins) == k) begin
          new_data = src[(k-1)*WIDTH +: WIDTH];
          new_ins  = ins;
        end
      end
    end
  end

  assign out_valid = (occ_q != EMPTY);
  assign accept    = in_valid && in_ready_q;
  assign xfer      = out_valid && out_ready;

  always_comb begin
    occ_d       = occ_q;
    out_data_d  = out_data_q;
    out_ins_d   = out_ins_q;
    skid_data_d = skid_data_q;
    skid_ins_d  = skid_ins_q;
    case (occ_q)
      EMPTY: begin
        if (accept) begin
          out_data_d = new_data;
          out_ins_d  = new_ins;
          occ_d      = ONE;
        end
      end
      ONE: begin
        if (accept && xfer) begin
          out_data_d = new_data;
          out_ins_d  = new_ins;
        end else if (accept) begin
          skid_data_d = new_data;
          skid_ins_d  = new_ins;
          occ_d       = FULL;
        end else if (xfer) begin
          occ_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the skid-to-output move can happen.
        if (xfer) begin
          out_data_d = skid_data_q;
          out_ins_d  = skid_ins_q;
          occ_d      = ONE;
        end
      end
      default: occ_d = EMPTY;
    endcase
    in_ready_d = (occ_d != FULL);
    sel_err_d  = accept && new_err;
    count_d    = xfer ? count_q + 16'd1 : count_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q       <= EMPTY;
      out_data_q  <= '0;
      out_ins_q   <= '0;
      skid_data_q <= '0;
      skid_ins_q  <= '0;
      in_ready_q  <= 1'b0;
      sel_err_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      occ_q       <= occ_d;
      out_data_q  <= out_data_d;
      out_ins_q   <= out_ins_d;
      skid_data_q <= skid_data_d;
      skid_ins_q  <= skid_ins_d;
      in_ready_q  <= in_ready_d;
      sel_err_q   <= sel_err_d;
      count_q     <= count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign a_o       = out_valid ? out_data_q : '0;
  assign out_ins   = out_valid ? out_ins_q : '0;
  assign sel_err   = sel_err_q;
  assign count     = count_q;
  assign occ_dbg_o = occ_q;

endmodule

// File: tb/tb_operand_mux_pipe.sv
// Directed bench for operand_mux_pipe: select sweep, override/error, backpressure, reset, wrap.
module tb_operand_mux_pipe;
  localparam int WIDTH = 40;
  localparam int NSRC  = 5;
  localparam int SELW  = 3;

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic                  d_in;
  logic [SELW-1:0]       ins;
  logic [NSRC*WIDTH-1:0] src;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      a_o;
  logic [SELW-1:0]       out_ins;
  logic                  sel_err;
  logic [15:0]           count;
  logic [1:0]            occ_dbg_o;

  int n_checks = 0;
  int n_fail   = 0;

  operand_mux_pipe #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .d_in(d_in), .ins(ins), .src(src), .out_valid(out_valid),
    .out_ready(out_ready), .a_o(a_o), .out_ins(out_ins), .sel_err(sel_err),
    .count(count), .occ_dbg_o(occ_dbg_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset in_ready got %b exp 0", in_ready); end
    n_checks++; if (a_o !== 40'h0) begin n_fail++; $display("FAIL reset a_o got %h exp 0", a_o); end
    n_checks++; if (out_ins !== 3'd0) begin n_fail++; $display("FAIL reset out_ins got %0d exp 0", out_ins); end
    n_checks++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL reset sel_err got %b exp 0", sel_err); end
    n_checks++; if (count !== 16'd0) begin n_fail++; $display("FAIL reset count got %0d exp 0", count); end
    rst_n = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset release in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_select_sweep();
    logic [WIDTH-1:0] exp_a [6];
    exp_a = '{40'h0, 40'h11, 40'h22, 40'h33, 40'h44, 40'h55};
    out_ready = 1'b1;
    d_in      = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      ins      = 3'(i);
      tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sweep%0d out_valid got %b exp 1", i, out_valid); end
      n_checks++; if (a_o !== exp_a[i]) begin n_fail++; $display("FAIL sweep%0d a_o got %h exp %h", i, a_o, exp_a[i]); end
      n_checks++; if (out_ins !== 3'(i)) begin n_fail++; $display("FAIL sweep%0d out_ins got %0d exp %0d", i, out_ins, i); end
      n_checks++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL sweep%0d sel_err got %b exp 0", i, sel_err); end
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (count !== 16'd6) begin n_fail++; $display("FAIL sweep count got %0d exp 6", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sweep drained out_valid got %b exp 0", out_valid); end
    n_checks++; if (a_o !== 40'h0) begin n_fail++; $display("FAIL sweep idle a_o got %h exp 0", a_o); end
  endtask

  task automatic test_override_error();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    d_in      = 1'b1;
    ins       = 3'd4;
    tick();
    in_valid = 1'b0;
    d_in     = 1'b0;
    n_checks++; if (a_o !== 40'h11) begin n_fail++; $display("FAIL override a_o got %h exp 11", a_o); end
    n_checks++; if (out_ins !== 3'd1) begin n_fail++; $display("FAIL override out_ins got %0d exp 1", out_ins); end
    n_checks++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL override sel_err got %b exp 0", sel_err); end
    tick();
    in_valid = 1'b1;
    ins      = 3'd7;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL error out_valid got %b exp 1", out_valid); end
    n_checks++; if (a_o !== 40'h0) begin n_fail++; $display("FAIL error a_o got %h exp 0", a_o); end
    n_checks++; if (out_ins !== 3'd0) begin n_fail++; $display("FAIL error out_ins got %0d exp 0", out_ins); end
    n_checks++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL error sel_err pulse got %b exp 1", sel_err); end
    tick();
    n_checks++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL error sel_err after got %b exp 0", sel_err); end
    n_checks++; if (count !== 16'd8) begin n_fail++; $display("FAIL error count got %0d exp 8", count); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    d_in      = 1'b0;
    in_valid  = 1'b1;
    ins       = 3'd2;
    tick();
    ins = 3'd3;
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp full in_ready got %b exp 0", in_ready); end
    n_checks++; if (a_o !== 40'h22) begin n_fail++; $display("FAIL bp head a_o got %h exp 22", a_o); end
    ins = 3'd4;
    tick();
    in_valid  = 1'b0;
    n_checks++; if (a_o !== 40'h22) begin n_fail++; $display("FAIL bp stable a_o got %h exp 22", a_o); end
    n_checks++; if (out_ins !== 3'd2) begin n_fail++; $display("FAIL bp stable out_ins got %0d exp 2", out_ins); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp still full in_ready got %b exp 0", in_ready); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp release in_ready got %b exp 1", in_ready); end
    n_checks++; if (a_o !== 40'h33) begin n_fail++; $display("FAIL bp second a_o got %h exp 33", a_o); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp drained out_valid got %b exp 0", out_valid); end
    n_checks++; if (count !== 16'd10) begin n_fail++; $display("FAIL bp count got %0d exp 10", count); end
  endtask

  task automatic test_mid_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    ins       = 3'd1;
    tick();
    ins = 3'd2;
    tick();
    in_valid = 1'b0;
    n_checks++; if (occ_dbg_o !== 2'd2) begin n_fail++; $display("FAIL midrst full occ got %0d exp 2", occ_dbg_o); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst out_valid got %b exp 0", out_valid); end
    n_checks++; if (count !== 16'd0) begin n_fail++; $display("FAIL midrst count got %0d exp 0", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0 || a_o !== 40'h0) begin n_fail++; $display("FAIL midrst stale cyc%0d out_valid %b a_o %h exp 0/0", i, out_valid, a_o); end
    end
    n_checks++; if (count !== 16'd0) begin n_fail++; $display("FAIL midrst count after got %0d exp 0", count); end
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    d_in      = 1'b0;
    in_valid  = 1'b1;
    ins       = 3'd3;
    tick();
    for (int i = 0; i < 65535; i++) tick();
    n_checks++; if (count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap preload count got %h exp ffff", count); end
    n_checks++; if (a_o !== 40'h33) begin n_fail++; $display("FAIL wrap stream a_o got %h exp 33", a_o); end
    in_valid = 1'b0;
    tick();
    n_checks++; if (count !== 16'h0000) begin n_fail++; $display("FAIL wrap count got %h exp 0000", count); end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    d_in      = 1'b0;
    ins       = '0;
    out_ready = 1'b0;
    src       = {40'h55, 40'h44, 40'h33, 40'h22, 40'h11};
    test_reset();
    test_select_sweep();
    test_override_error();
    test_backpressure();
    test_mid_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/operand_mux_pipe.md
OPERAND_MUX_PIPE -- requirements
Module: operand_mux_pipe

Interface
REQ-001 The block SHALL declare parameter WIDTH, default 40, as the operand width in bits.
REQ-002 The block SHALL declare parameter NSRC, default 5, as the number of operand sources (1..7).
REQ-003 The block SHALL declare parameter SELW, default 3, as the width of the instruction select code.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, the reset: synchronous, active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit, meaning a select request is present.
REQ-007 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts a request this cycle.
REQ-008 The block SHALL have port d_in, input, 1 bit, the external-load override that forces source 1.
REQ-009 The block SHALL have port ins, input, SELW bits, the select code (0 = zero, k = source k).
REQ-010 The block SHALL have port src, input, NSRC*WIDTH bits, the sources packed so that source k occupies bits [k*WIDTH-1:(k-1)*WIDTH].
REQ-011 The block SHALL have port out_valid, output, 1 bit, meaning a_o holds a selected operand.
REQ-012 The block SHALL have port out_ready, input, 1 bit, the consumer acceptance.
REQ-013 The block SHALL have port a_o, output, WIDTH bits, the selected operand.
REQ-014 The block SHALL have port out_ins, output, SELW bits, the effective select code travelling with a_o.
REQ-015 The block SHALL have port sel_err, output, 1 bit, a one-cycle pulse flagging an out-of-range select.
REQ-016 The block SHALL have port count, output, 16 bits, the number of operands delivered.

Function
REQ-017 A request SHALL be accepted in a cycle when in_valid=1 and in_ready=1.
REQ-018 Operands SHALL be selected from the src value sampled in the accept cycle.
REQ-019 Selection SHALL be: d_in=1 -> source 1, with an effective code of 1 regardless of ins; d_in=0 and ins=0 -> all zeros; d_in=0 and 1<=ins<=NSRC -> source ins; d_in=0 and ins>NSRC -> all zeros.
REQ-020 On acceptance with d_in=0 and ins>NSRC, sel_err SHALL be 1 in the next cycle only, and the operand SHALL still be delivered, with out_ins=0.
REQ-021 Datapath: a 2-entry FIFO (output register plus skid register) SHALL be used, with a latency of exactly 1 cycle from acceptance to out_valid when the FIFO is empty.
REQ-022 in_ready SHALL be 1 when and only when fewer than 2 entries are held; it SHALL be registered and SHALL not depend combinationally on out_ready.
REQ-023 A transfer SHALL complete when out_valid=1 and out_ready=1; a_o and out_ins SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 Order SHALL be preserved: the skid entry SHALL move to the output register on the cycle the output entry transfers.
REQ-025 Simultaneous accept and transfer while 1 entry is held SHALL keep the occupancy at 1, with the new operand in the output register on the next cycle.
REQ-026 Simultaneous accept and transfer while 2 entries are held cannot occur, because in_ready=0 in that state.
REQ-027 Occupancy states SHALL be EMPTY (0), ONE (1) and FULL (2). Transitions:
- EMPTY -> ONE on accept.
- ONE -> FULL on accept without transfer.
- ONE -> EMPTY on transfer without accept.
- FULL -> ONE on transfer.
REQ-028 count SHALL increment by 1 on each completed output transfer, SHALL wrap from 16'hFFFF to 0, and SHALL not saturate.
REQ-029 a_o SHALL be all zeros whenever out_valid=0.

Reset
REQ-030 While rst_n=0 at a rising clk edge, the block SHALL set the following on that edge: occupancy=EMPTY, out_valid=0, in_ready=0, a_o=0, out_ins=0, sel_err=0, count=0.
REQ-031 In the first cycle after rst_n returns to 1, in_ready SHALL be 1.
REQ-032 A reset asserted mid-operation SHALL discard both held entries without delivering them, and count SHALL not increment for them.
REQ-033 Requests presented while rst_n=0 SHALL be ignored.

Verification
REQ-034 Scenario (reset): rst_n=0 for 2 cycles -> all outputs 0; first cycle after release -> in_ready=1.
REQ-035 Scenario (select sweep): WIDTH=40, NSRC=5, source k=40'h11*k, out_ready=1, ins=0..5 with d_in=0 -> a_o sequence 0, 0x11, 0x22, 0x33, 0x44, 0x55, each 1 cycle after its accept; count=6.
REQ-036 Scenario (override and error): d_in=1, ins=4 -> a_o=0x11 and out_ins=1. d_in=0, ins=7 -> a_o=0, out_ins=0, and sel_err pulses for exactly 1 cycle.
REQ-037 Scenario (backpressure): out_ready=0 with 3 back-to-back requests -> 2 accepted, in_ready=0 in the cycle after the second accept, and a_o stable. Raising out_ready -> in_ready=1 on the next cycle, and the operands drain in accept order.
REQ-038 Scenario (mid-operation reset): FULL state, then rst_n=0 for 1 cycle -> out_valid=0, count unchanged at 0, and no stale operand appears afterwards.
REQ-039 Scenario (wrap): preload count to 16'hFFFF via 65535 transfers, then 1 more transfer -> count=0.
